// File: rtl/pipe_pkg.sv
// Shared types for the pipeline sequencer: per-stage metadata and the bubble value.
package pipe_pkg;

  localparam int RD_W   = 5;
  localparam int KILL_W = 3;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            wen;
    logic            mem_read;
  } stage_meta_t;

  localparam stage_meta_t BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying cycles, holding at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: owns EX/MEM/WB metadata and decides advance, stall,
// bubble or flush each cycle. Priority: mem_busy > redirect > load_stall > advance.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int FETCH_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             de_valid,
  input  logic [4:0]       de_rd,
  input  logic             de_wen,
  input  logic             de_mem_read,
  input  logic             load_stall,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             fetch_stall,
  output logic             de_stall,
  output logic             de_flush,
  output logic             ex_valid,
  output logic [4:0]       ex_rd,
  output logic             mem_read,
  output logic             mem_valid,
  output logic [4:0]       mem_rd,
  output logic             mem_read_r,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [CNT_W-1:0] cnt_load_stall,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_mem_busy
);

  localparam logic [KILL_W-1:0] KILL_INIT = KILL_W'(FETCH_LAT);

  stage_meta_t       ex_q, mem_q, wb_q;
  stage_meta_t       de_meta;
  logic [KILL_W-1:0] kill_q;
  logic              kill_active;
  logic              redir;
  logic              do_busy, do_redir, do_ls;
  logic              unused_wb;

  // Resolve the cycle's action by priority; stall/flush are forced low while in reset.
  always_comb begin
    kill_active = (kill_q != '0);
    redir       = ex_redirect & ex_q.valid;
    do_busy     = mem_busy;
    do_redir    = !mem_busy & redir;
    do_ls       = !mem_busy & !redir & load_stall;
    fetch_stall = !reset & (do_busy | do_ls);
    de_stall    = !reset & (do_busy | do_ls);
    de_flush    = !reset & do_redir;
    de_meta          = BUBBLE;
    de_meta.valid    = de_valid & !kill_active;
    de_meta.rd       = de_rd & {RD_W{de_wen}};
    de_meta.wen      = de_wen;
    de_meta.mem_read = de_mem_read;
  end

  // Stage registers: freeze EX/MEM on mem_busy, bubble EX on redirect or load-use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else if (do_busy) begin
      wb_q  <= BUBBLE;
    end else if (do_redir || do_ls) begin
      ex_q  <= BUBBLE;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end else begin
      ex_q  <= de_meta;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Squash window for fetches already in flight when a redirect is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kill_q <= '0;
    end else if (!mem_busy) begin
      if (redir) begin
        kill_q <= KILL_INIT;
      end else if (kill_active) begin
        kill_q <= kill_q - 1'b1;
      end
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_rd      = ex_q.rd & {RD_W{ex_q.wen}};
  assign mem_read   = ex_q.valid & ex_q.mem_read;
  assign mem_valid  = mem_q.valid;
  assign mem_rd     = mem_q.rd & {RD_W{mem_q.wen}};
  assign mem_read_r = mem_q.valid & mem_q.mem_read;
  assign wb_valid   = wb_q.valid;
  assign wb_rd      = wb_q.rd & {RD_W{wb_q.wen}};
  assign unused_wb  = wb_q.mem_read;

  sat_counter #(.W(CNT_W)) u_cnt_load_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (do_ls),
    .count (cnt_load_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .reset (reset),
    .inc   (do_redir),
    .count (cnt_flush)
  );

  sat_counter #(.W(CNT_W)) u_cnt_mem_busy (
    .clk   (clk),
    .reset (reset),
    .inc   (do_busy),
    .count (cnt_mem_busy)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             de_valid, de_wen, de_mem_read;
  logic [4:0]       de_rd;
  logic             load_stall, ex_redirect, mem_busy;
  logic             fetch_stall, de_stall, de_flush;
  logic             ex_valid, mem_read, mem_valid, mem_read_r, wb_valid;
  logic [4:0]       ex_rd, mem_rd, wb_rd;
  logic [CNT_W-1:0] cnt_load_stall, cnt_flush, cnt_mem_busy;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.CNT_W(CNT_W), .FETCH_LAT(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .de_valid       (de_valid),
    .de_rd          (de_rd),
    .de_wen         (de_wen),
    .de_mem_read    (de_mem_read),
    .load_stall     (load_stall),
    .ex_redirect    (ex_redirect),
    .mem_busy       (mem_busy),
    .fetch_stall    (fetch_stall),
    .de_stall       (de_stall),
    .de_flush       (de_flush),
    .ex_valid       (ex_valid),
    .ex_rd          (ex_rd),
    .mem_read       (mem_read),
    .mem_valid      (mem_valid),
    .mem_rd         (mem_rd),
    .mem_read_r     (mem_read_r),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .cnt_load_stall (cnt_load_stall),
    .cnt_flush      (cnt_flush),
    .cnt_mem_busy   (cnt_mem_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_de(input logic v, input logic [4:0] rd, input logic wen, input logic mr);
    de_valid    = v;
    de_rd       = rd;
    de_wen      = wen;
    de_mem_read = mr;
  endtask

  initial begin
    reset = 1'b1;
    drive_de(0, 0, 0, 0);
    load_stall  = 0;
    ex_redirect = 0;
    mem_busy    = 1;
    #3;
    chk("rst_fetch_stall", fetch_stall, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_cnt_mem_busy", cnt_mem_busy, 0);
    mem_busy = 0;
    #9 reset = 1'b0;

    // basic advance of a load
    drive_de(1, 5, 1, 1);
    tick();
    chk("t1_ex_valid", ex_valid, 1);
    chk("t1_ex_rd", ex_rd, 5);
    chk("t1_mem_read", mem_read, 1);
    drive_de(0, 0, 0, 0);
    tick();
    chk("t1_mem_rd", mem_rd, 5);
    chk("t1_mem_read_r", mem_read_r, 1);
    chk("t1_ex_bubble", ex_valid, 0);

    // load-use bubble
    drive_de(1, 5, 1, 1);
    tick();
    drive_de(1, 6, 1, 0);
    load_stall = 1;
    #1;
    chk("t2_de_stall", de_stall, 1);
    chk("t2_fetch_stall", fetch_stall, 1);
    chk("t2_no_flush", de_flush, 0);
    tick();
    load_stall = 0;
    chk("t2_ex_bubble", ex_valid, 0);
    chk("t2_mem_rd", mem_rd, 5);
    chk("t2_cnt_ls", cnt_load_stall, 1);
    tick();
    chk("t2_resume_ex_rd", ex_rd, 6);
    chk("t2_resume_ex_valid", ex_valid, 1);

    // redirect beats load_stall; one fetch squashed
    ex_redirect = 1;
    load_stall  = 1;
    drive_de(1, 8, 1, 0);
    #1;
    chk("t3_flush", de_flush, 1);
    chk("t3_de_stall", de_stall, 0);
    chk("t3_fetch_stall", fetch_stall, 0);
    tick();
    ex_redirect = 0;
    load_stall  = 0;
    chk("t3_ex_bubble", ex_valid, 0);
    chk("t3_mem_rd", mem_rd, 6);
    chk("t3_cnt_flush", cnt_flush, 1);
    chk("t3_cnt_ls", cnt_load_stall, 1);
    drive_de(1, 10, 1, 0);
    tick();
    chk("t3_killed", ex_valid, 0);
    drive_de(1, 11, 1, 0);
    tick();
    chk("t3_accept_valid", ex_valid, 1);
    chk("t3_accept_rd", ex_rd, 11);

    // mem_busy freeze for three cycles, redirect held off
    drive_de(1, 3, 1, 0);
    tick();
    drive_de(1, 7, 1, 0);
    tick();
    chk("t4_pre_ex_rd", ex_rd, 7);
    chk("t4_pre_mem_rd", mem_rd, 3);
    drive_de(1, 12, 1, 0);
    mem_busy    = 1;
    ex_redirect = 1;
    #1;
    chk("t4_fetch_stall", fetch_stall, 1);
    chk("t4_de_stall", de_stall, 1);
    chk("t4_no_flush", de_flush, 0);
    tick();
    chk("t4_wb_bubble", wb_valid, 0);
    chk("t4_wb_rd", wb_rd, 0);
    chk("t4_ex_hold", ex_rd, 7);
    chk("t4_mem_hold", mem_rd, 3);
    tick();
    tick();
    chk("t4_cnt_mb", cnt_mem_busy, 3);
    chk("t4_ex_hold3", ex_rd, 7);
    chk("t4_mem_hold3", mem_rd, 3);
    chk("t4_cnt_flush_held", cnt_flush, 1);
    mem_busy = 0;
    #1;
    chk("t4_flush_after", de_flush, 1);
    tick();
    ex_redirect = 0;
    chk("t4_cnt_flush", cnt_flush, 2);
    chk("t4_ex_bubble", ex_valid, 0);
    chk("t4_mem_rd", mem_rd, 7);
    chk("t4_wb_rd", wb_rd, 3);
    chk("t4_wb_valid", wb_valid, 1);
    drive_de(0, 0, 0, 0);
    tick();

    // no write-enable masks rd; unqualified redirect ignored
    drive_de(1, 9, 0, 0);
    ex_redirect = 1;
    #1;
    chk("t5_no_flush", de_flush, 0);
    tick();
    ex_redirect = 0;
    chk("t5_ex_rd", ex_rd, 0);
    chk("t5_ex_valid", ex_valid, 1);
    chk("t5_cnt_flush", cnt_flush, 2);

    // saturation of the 4-bit load-stall counter
    drive_de(0, 0, 0, 0);
    load_stall = 1;
    for (int i = 0; i < 13; i++) tick();
    chk("t6_cnt_ls_14", cnt_load_stall, 14);
    for (int i = 0; i < 7; i++) tick();
    chk("t6_cnt_ls_sat", cnt_load_stall, 15);
    load_stall = 0;

    // async reset mid-cycle
    drive_de(1, 4, 1, 1);
    tick();
    chk("t6_pre_ex_valid", ex_valid, 1);
    mem_busy = 1;
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_ex_valid", ex_valid, 0);
    chk("t6_rst_ex_rd", ex_rd, 0);
    chk("t6_rst_mem_valid", mem_valid, 0);
    chk("t6_rst_wb_valid", wb_valid, 0);
    chk("t6_rst_fetch_stall", fetch_stall, 0);
    chk("t6_rst_de_stall", de_stall, 0);
    chk("t6_rst_cnt_ls", cnt_load_stall, 0);
    chk("t6_rst_cnt_flush", cnt_flush, 0);
    chk("t6_rst_cnt_mb", cnt_mem_busy, 0);
    #1 reset = 1'b0;
    mem_busy = 0;
    drive_de(1, 13, 1, 0);
    tick();
    chk("t6_post_ex_valid", ex_valid, 1);
    chk("t6_post_ex_rd", ex_rd, 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
